cobs_stream_encoder: RTL and testbench

//  Native, parametrised COBS framing encoder for AXI-Stream byte packets.
//  - Replaces the third-party encoder wrapper; no external library dependency.
//  - Adds a configurable maximum run length and an optional 0x00 frame delimiter.
//  - Sits between packet producers and the UART/USB byte transport in the host link.

---
 rtl/cobs_stream_encoder.sv | 191 +++++++++++++++++++
 tb/tb_cobs_stream_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cobs_stream_encoder.sv
// COBS framing encoder for AXI-Stream byte packets, with a configurable group length
// and an optional 0x00 frame delimiter.
//
// state      | meaning
// FILL       | accepting raw bytes; non-zero bytes go into the group buffer
// SEND_CODE  | presenting the group code byte (n+1)
// SEND_DATA  | presenting buffered group bytes buf[0..n-1]
// SEND_TAIL  | presenting the extra 0x01 group for a frame that ended on a zero byte
// SEND_DELIM | presenting the 0x00 frame delimiter with tlast
module cobs_stream_encoder #(
    parameter int MAX_RUN          = 254,
    parameter int APPEND_DELIMITER = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] raw_tdata_i,
    input  logic       raw_tvalid_i,
    output logic       raw_tready_o,
    input  logic       raw_tlast_i,
    input  logic       raw_tuser_i,
    output logic [7:0] enc_tdata_o,
    output logic       enc_tvalid_o,
    input  logic       enc_tready_i,
    output logic       enc_tlast_o,
    output logic       enc_tuser_o
);
    localparam int NW     = $clog2(MAX_RUN + 1);
    localparam int IW     = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
    localparam bit APPEND = (APPEND_DELIMITER != 0);

    typedef enum logic [2:0] {
        FILL,
        SEND_CODE,
        SEND_DATA,
        SEND_TAIL,
        SEND_DELIM
    } state_t;

    state_t          state_q;
    logic [7:0]      buf_q [MAX_RUN];
    logic [NW-1:0]   n_q;
    logic [NW-1:0]   rd_q;
    logic            err_q;
    logic            final_q;
    logic            tail_q;
    logic [7:0]      tdata_q;
    logic            tvalid_q;
    logic            tlast_q;
    logic            tuser_q;
    logic            tready_q;

    logic            acc;
    logic            hs;
    logic            byte_nz;
    logic            close_d;
    logic            err_d;
    logic            grp_done;
    logic            to_tail;
    logic            to_end;
    logic            next_fill;
    logic            frame_done;
    logic            last_first;
    logic            last_next;
    logic [NW-1:0]   n_inc;
    logic [NW-1:0]   rd_inc;
    logic [7:0]      code_d;

    always_comb begin
        acc        = (state_q == FILL) & tready_q & raw_tvalid_i;
        hs         = tvalid_q & enc_tready_i;
        byte_nz    = (raw_tdata_i != 8'h00);
        n_inc      = n_q + NW'(1);
        rd_inc     = rd_q + NW'(1);
        // A full group closes on its own; the following byte opens a new group.
        close_d    = ~byte_nz | raw_tlast_i | (n_inc == NW'(MAX_RUN));
        code_d     = byte_nz ? (8'(n_inc) + 8'd1) : (8'(n_q) + 8'd1);
        err_d      = err_q | (acc & raw_tuser_i);
        grp_done   = hs & (((state_q == SEND_CODE) & (n_q == '0)) |
                           ((state_q == SEND_DATA) & (rd_q == n_q)));
        to_tail    = grp_done & tail_q;
        to_end     = (grp_done & ~tail_q & final_q) | ((state_q == SEND_TAIL) & hs);
        next_fill  = grp_done & ~tail_q & ~final_q;
        frame_done = (to_end & ~APPEND) | ((state_q == SEND_DELIM) & hs);
        // Without a delimiter the frame's last data byte carries tlast itself.
        last_first = (n_q == NW'(1)) & final_q & ~tail_q & ~APPEND;
        last_next  = (rd_inc == n_q) & final_q & ~tail_q & ~APPEND;
    end

    always_ff @(posedge clk_i) begin
        if (acc && byte_nz) begin
            buf_q[n_q[IW-1:0]] <= raw_tdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= FILL;
            n_q      <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            final_q  <= 1'b0;
            tail_q   <= 1'b0;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            tready_q <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (acc) begin
                        err_q <= err_d;
                        if (byte_nz) begin
                            n_q <= n_inc;
                        end
                        if (close_d) begin
                            state_q  <= SEND_CODE;
                            tdata_q  <= code_d;
                            tvalid_q <= 1'b1;
                            tlast_q  <= 1'b0;
                            tuser_q  <= 1'b0;
                            tready_q <= 1'b0;
                            final_q  <= raw_tlast_i;
                            tail_q   <= raw_tlast_i & ~byte_nz;
                        end
                    end
                end
                SEND_CODE: begin
                    if (hs && (n_q != '0)) begin
                        state_q <= SEND_DATA;
                        tdata_q <= buf_q[0];
                        rd_q    <= NW'(1);
                        tlast_q <= last_first;
                        tuser_q <= last_first & err_q;
                    end
                end
                SEND_DATA: begin
                    if (hs && (rd_q != n_q)) begin
                        tdata_q <= buf_q[rd_q[IW-1:0]];
                        rd_q    <= rd_inc;
                        tlast_q <= last_next;
                        tuser_q <= last_next & err_q;
                    end
                end
                default: ;
            endcase

            if (grp_done) begin
                n_q <= '0;
            end
            if (to_tail) begin
                state_q  <= SEND_TAIL;
                tdata_q  <= 8'h01;
                tvalid_q <= 1'b1;
                tlast_q  <= ~APPEND;
                tuser_q  <= ~APPEND & err_q;
            end
            if (next_fill) begin
                state_q  <= FILL;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tuser_q  <= 1'b0;
                tready_q <= 1'b1;
            end
            if (to_end && APPEND) begin
                state_q  <= SEND_DELIM;
                tdata_q  <= 8'h00;
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b1;
                tuser_q  <= err_q;
            end
            if (frame_done) begin
                state_q  <= FILL;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tuser_q  <= 1'b0;
                tready_q <= 1'b1;
                err_q    <= 1'b0;
                final_q  <= 1'b0;
                tail_q   <= 1'b0;
            end
        end
    end

    assign raw_tready_o = tready_q & ~reset_i;
    assign enc_tdata_o  = tdata_q;
    assign enc_tvalid_o = tvalid_q & ~reset_i;
    assign enc_tlast_o  = tlast_q & ~reset_i;
    assign enc_tuser_o  = tuser_q & ~reset_i;

endmodule

// File: tb/tb_cobs_stream_encoder.sv
// Directed bench for cobs_stream_encoder: default instance (254, delimiter) and a
// short-run instance (MAX_RUN=4, no delimiter).
module tb_cobs_stream_encoder;
    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] r_d, r4_d, e_d, e4_d;
    logic       r_v, r_l, r_u, r_rdy, e_v, e_l, e_u, e_rdy;
    logic       r4_v, r4_l, r4_u, r4_rdy, e4_v, e4_l, e4_u, e4_rdy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [9:0] rx_q[$];
    int         rx_first;
    int         rx_last;

    initial forever #5 clk = ~clk;

    cobs_stream_encoder dut (
        .clk_i(clk), .reset_i(reset),
        .raw_tdata_i(r_d), .raw_tvalid_i(r_v), .raw_tready_o(r_rdy),
        .raw_tlast_i(r_l), .raw_tuser_i(r_u),
        .enc_tdata_o(e_d), .enc_tvalid_o(e_v), .enc_tready_i(e_rdy),
        .enc_tlast_o(e_l), .enc_tuser_o(e_u)
    );

    cobs_stream_encoder #(.MAX_RUN(4), .APPEND_DELIMITER(0)) dut4 (
        .clk_i(clk), .reset_i(reset),
        .raw_tdata_i(r4_d), .raw_tvalid_i(r4_v), .raw_tready_o(r4_rdy),
        .raw_tlast_i(r4_l), .raw_tuser_i(r4_u),
        .enc_tdata_o(e4_d), .enc_tvalid_o(e4_v), .enc_tready_i(e4_rdy),
        .enc_tlast_o(e4_l), .enc_tuser_o(e4_u)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input logic [63:0] v, input int n);
        tx_q.delete();
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic set_exp(input logic [63:0] v, input int n);
        exp_q.delete();
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic drive(input bit s4, input logic [7:0] d, input logic l,
                         input logic u, input logic v);
        if (s4) begin
            r4_d = d; r4_l = l; r4_u = u; r4_v = v;
        end else begin
            r_d = d; r_l = l; r_u = u; r_v = v;
        end
    endtask

    // Called and returns on a negedge; each byte is accepted on the posedge in between.
    task automatic send_frame(input bit s4, input bit with_last, input int user_idx);
        for (int i = 0; i < tx_q.size(); i++) begin
            int k;
            k = 0;
            drive(s4, tx_q[i], with_last && (i == tx_q.size() - 1), (i == user_idx), 1'b1);
            while (!(s4 ? r4_rdy : r_rdy) && k < 3000) begin
                @(negedge clk);
                k++;
            end
            if (k >= 3000) begin
                chk("tx_timeout", k, 0);
                break;
            end
            @(negedge clk);
        end
        drive(s4, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic recv(input bit s4, input int n, input int pct_low);
        bit         stalled;
        logic [9:0] hold;
        int         cyc;
        stalled  = 1'b0;
        hold     = '0;
        cyc      = 0;
        rx_first = -1;
        rx_last  = -1;
        rx_q.delete();
        while (rx_q.size() < n && cyc < 3000) begin
            logic       v;
            logic [9:0] beat;
            bit         rdy;
            @(negedge clk);
            cyc++;
            v    = s4 ? e4_v : e_v;
            beat = s4 ? {e4_d, e4_l, e4_u} : {e_d, e_l, e_u};
            if (stalled) chk("stall_hold", {v, beat}, {1'b1, hold});
            if (v && rx_first < 0) rx_first = cyc;
            rdy = ($urandom_range(99) >= pct_low);
            if (s4) e4_rdy = rdy; else e_rdy = rdy;
            if (v && rdy) begin
                rx_q.push_back(beat);
                rx_last = cyc;
            end
            stalled = v && !rdy;
            hold    = beat;
        end
        chk("rx_count", rx_q.size(), n);
        if (s4) e4_rdy = 1'b1; else e_rdy = 1'b1;
    endtask

    task automatic check_frame(input string tag, input bit user);
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            bit lastb;
            lastb = (i == exp_q.size() - 1);
            chk($sformatf("%s[%0d]", tag, i), rx_q[i], {exp_q[i], lastb, lastb & user});
        end
    endtask

    task automatic idle_check(input string tag, input bit s4);
        repeat (3) @(negedge clk);
        if (s4) chk(tag, {e4_v, r4_rdy}, 2'b01);
        else    chk(tag, {e_v, r_rdy}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        e_rdy  = 1'b1;
        e4_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out",  {e_v, e_l, e_u, r_rdy}, 4'b0000);
        chk("rst_out4", {e4_v, e4_l, e4_u, r4_rdy}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst",  {e_v, r_rdy}, 2'b01);
        chk("post_rst4", {e4_v, r4_rdy}, 2'b01);

        // T1: zero inside the frame
        set_tx(64'h11220033, 4);
        set_exp(64'h031122023300, 6);
        fork
            send_frame(1'b0, 1'b1, -1);
            recv(1'b0, 6, 0);
        join
        check_frame("t1", 1'b0);
        idle_check("t1_idle", 1'b0);

        // T2a: lone zero, with first-code latency held under backpressure
        e_rdy = 1'b0;
        set_tx(64'h00, 1);
        send_frame(1'b0, 1'b1, -1);
        chk("t2_latency", {e_v, e_d}, {1'b1, 8'h01});
        set_exp(64'h010100, 3);
        recv(1'b0, 3, 0);
        check_frame("t2a", 1'b0);
        idle_check("t2a_idle", 1'b0);

        // T2b: frame ending on a zero byte
        set_tx(64'h1100, 2);
        set_exp(64'h02110100, 4);
        fork
            send_frame(1'b0, 1'b1, -1);
            recv(1'b0, 4, 0);
        join
        check_frame("t2b", 1'b0);

        // T3a: exactly one full group, back-to-back output
        tx_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hFF);
        for (int i = 1; i <= 254; i++) begin
            tx_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        exp_q.push_back(8'h00);
        fork
            send_frame(1'b0, 1'b1, -1);
            recv(1'b0, 256, 0);
        join
        check_frame("t3a", 1'b0);
        chk("t3a_b2b", rx_last - rx_first + 1, 256);

        // T3b: full group plus one byte
        tx_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hFF);
        for (int i = 1; i <= 255; i++) tx_q.push_back(8'(i));
        for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        fork
            send_frame(1'b0, 1'b1, -1);
            recv(1'b0, 258, 0);
        join
        check_frame("t3b", 1'b0);
        idle_check("t3b_idle", 1'b0);

        // T4: short run, no delimiter, error flag on second byte
        set_tx(64'h0102030405, 5);
        set_exp(64'h05010203040205, 7);
        fork
            send_frame(1'b1, 1'b1, 1);
            recv(1'b1, 7, 0);
        join
        check_frame("t4", 1'b1);
        idle_check("t4_idle", 1'b1);

        // T5: T1 repeated under random downstream backpressure
        for (int f = 0; f < 100; f++) begin
            set_tx(64'h11220033, 4);
            set_exp(64'h031122023300, 6);
            fork
                send_frame(1'b0, 1'b1, -1);
                recv(1'b0, 6, 30);
            join
            check_frame("t5", 1'b0);
        end
        idle_check("t5_idle", 1'b0);

        // T6: reset in the middle of a group, then a clean frame
        set_tx(64'hAABB, 2);
        send_frame(1'b0, 1'b0, -1);
        chk("t6_no_out", e_v, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst", {e_v, e_l, e_u, r_rdy}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_tx(64'h11, 1);
        set_exp(64'h021100, 3);
        fork
            send_frame(1'b0, 1'b1, -1);
            recv(1'b0, 3, 0);
        join
        check_frame("t6", 1'b0);
        idle_check("t6_idle", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
